// File: rtl/bscant_pkg.sv
// Shared constants and host-visible status layout for the Bscan
// readback path.
package bscant_pkg;

  localparam int BSCAN_WIDTH = 32;
  localparam int BSCAN_DEPTH = 8;
  localparam int BSCAN_CNT_W = 8;
  localparam int BSCAN_LVL_W = $clog2(BSCAN_DEPTH) + 1;

  typedef struct packed {
    logic                   overflow;
    logic [BSCAN_CNT_W-1:0] dropCount;
    logic [BSCAN_LVL_W-1:0] level;
  } bscanStatus_t;

  function automatic bscanStatus_t packStatus(
    input logic                   ovf,
    input logic [BSCAN_CNT_W-1:0] cnt,
    input logic [BSCAN_LVL_W-1:0] lvl
  );
    packStatus = '{overflow: ovf, dropCount: cnt, level: lvl};
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO core: wrap-bit pointers, unreset storage,
// combinational head read.
module sync_fifo_core
  import bscant_pkg::*;
#(
  parameter int WIDTH = BSCAN_WIDTH,
  parameter int DEPTH = BSCAN_DEPTH
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wrData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW-1:0] == rdPtr[AW-1:0])
              && (wrPtr[AW] != rdPtr[AW]);
  assign level = wrPtr - rdPtr;
  assign head  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage carries no reset; only pointers define validity.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/bscan_readback_buffer.sv
// Elastic buffer from the unstallable Bscan readback pipe to the
// host indication pipe, with drop accounting.
module bscan_readback_buffer
  import bscant_pkg::*;
#(
  parameter int WIDTH = BSCAN_WIDTH,
  parameter int DEPTH = BSCAN_DEPTH,
  parameter int CNT_W = BSCAN_CNT_W
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_enq__ENA,
  input  logic [WIDTH-1:0]       in_enq_v,
  output logic                   in_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  input  logic                   out_enq__RDY,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic [CNT_W-1:0] dropCnt;
  logic ovf;

  assign pop  = !empty && out_enq__RDY;
  assign push = in_enq__ENA && (!full || pop);
  assign drop = in_enq__ENA && full && !pop;

  sync_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uCore (
    .CLK    (CLK),
    .nRST   (nRST),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wrData (in_enq_v),
    .full   (full),
    .empty  (empty),
    .level  (level),
    .head   (out_enq_v)
  );

  // Drops during a flush cycle are not counted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf     <= 1'b0;
      dropCnt <= '0;
    end else if (flush) begin
      ovf     <= 1'b0;
      dropCnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (dropCnt != '1) dropCnt <= dropCnt + 1'b1;
    end
  end

  assign out_enq__ENA = !empty;
  assign in_enq__RDY  = !full;
  assign overflow     = ovf;
  assign drop_count   = dropCnt;

endmodule

// File: tb/tb_bscan_readback_buffer.sv
// Directed plus randomized bench for bscan_readback_buffer against
// a queue-based reference model.
module tb_bscan_readback_buffer;

  localparam int W = 32;
  localparam int D = 8;
  localparam int C = 8;
  localparam int SAT = (1 << C) - 1;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         inEna = 1'b0;
  logic [W-1:0] inV = '0;
  logic         inRdy;
  logic         outEna;
  logic [W-1:0] outV;
  logic         outRdy = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   level;
  logic         overflow;
  logic [C-1:0] dropCount;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];
  bit mOvf = 1'b0;
  int mDrops = 0;

  always #5 CLK = ~CLK;

  bscan_readback_buffer #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (inEna),
    .in_enq_v     (inV),
    .in_enq__RDY  (inRdy),
    .out_enq__ENA (outEna),
    .out_enq_v    (outV),
    .out_enq__RDY (outRdy),
    .flush        (flush),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (dropCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkStatus(input string tag);
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(mOvf));
    chk({tag, ".drops"}, 64'(dropCount), 64'(mDrops));
    chk({tag, ".inRdy"}, 64'(inRdy), 64'(q.size() != D));
  endtask

  // One clock: drive at negedge, check head before the edge, then
  // advance the model and check status after the edge.
  task automatic cycle(input bit enq, input logic [W-1:0] v,
                       input bit rdy, input bit fl, input string tag);
    bit doPop;
    bit isFull;
    @(negedge CLK);
    inEna = enq;
    inV = v;
    outRdy = rdy;
    flush = fl;
    #1;
    chk({tag, ".ena"}, 64'(outEna), 64'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".head"}, 64'(outV), 64'(q[0]));
    @(posedge CLK);
    #1;
    doPop = (q.size() != 0) && rdy;
    isFull = (q.size() == D);
    if (fl) begin
      q.delete();
      mOvf = 1'b0;
      mDrops = 0;
    end else begin
      if (doPop) void'(q.pop_front());
      if (enq && (!isFull || doPop)) q.push_back(v);
      else if (enq) begin
        mOvf = 1'b1;
        if (mDrops < SAT) mDrops++;
      end
    end
    chkStatus(tag);
  endtask

  initial begin
    #12;
    chk("rst.level", 64'(level), 64'd0);
    chk("rst.ena", 64'(outEna), 64'd0);
    chk("rst.inRdy", 64'(inRdy), 64'd1);
    chk("rst.ovf", 64'(overflow), 64'd0);
    chk("rst.drops", 64'(dropCount), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    cycle(1, 32'hA5A5_0001, 0, 0, "lat1");
    chk("lat.enaRise", 64'(outEna), 64'd1);
    cycle(1, 32'hA5A5_0002, 0, 0, "lat2");
    cycle(1, 32'hA5A5_0003, 0, 0, "lat3");
    chk("lat.level3", 64'(level), 64'd3);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, "latDrain");
    chk("lat.level0", 64'(level), 64'd0);

    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'(8'h10 + i), 0, 0, "fill");
      if (i == 7) chk("fill.inRdy8", 64'(inRdy), 64'd0);
    end
    chk("fill.drops2", 64'(dropCount), 64'd2);
    chk("fill.ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("fill.drainVal", 64'(outV), 64'(8'h10 + i));
      cycle(0, '0, 1, 0, "fillDrain");
    end

    for (int i = 0; i < 8; i++) cycle(1, $urandom, 0, 0, "full");
    cycle(1, 32'h99, 1, 0, "fullPP");
    chk("fullPP.level", 64'(level), 64'd8);
    chk("fullPP.drops", 64'(dropCount), 64'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fullPP.last", 64'(outV), 64'h99);
      cycle(0, '0, 1, 0, "fullDrain");
    end

    for (int i = 0; i < 8; i++) cycle(1, $urandom, 0, 0, "satFill");
    for (int i = 0; i < 300; i++) cycle(1, $urandom, 0, 0, "sat");
    chk("sat.drops", 64'(dropCount), 64'(SAT));
    cycle(0, '0, 0, 1, "satFlush");
    chk("sat.flushDrops", 64'(dropCount), 64'd0);

    for (int i = 0; i < 4; i++) cycle(1, $urandom, 0, 0, "fp");
    cycle(1, 32'h55, 1, 1, "fpFlush");
    chk("fp.level", 64'(level), 64'd0);
    chk("fp.ena", 64'(outEna), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, "fpAfter");

    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 2) != 0), $urandom,
            bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 60) == 0), "rand");

    cycle(0, '0, 0, 1, "preRst");
    for (int i = 0; i < 3; i++) cycle(1, $urandom, 0, 0, "rstFill");
    #2;
    nRST = 1'b0;
    inEna = 1'b0;
    #1;
    q.delete();
    mOvf = 1'b0;
    mDrops = 0;
    chk("arst.level", 64'(level), 64'd0);
    chk("arst.ena", 64'(outEna), 64'd0);
    chk("arst.ovf", 64'(overflow), 64'd0);
    chk("arst.drops", 64'(dropCount), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, "postRst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
